// File: rtl/serial_add_if.sv
// Request/result bundle between a requester and the bit-serial adder sequencer.
// The master drives operands and the handshake; the slave returns status and results.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
        output start_valid, a_in, b_in, cin, abort,
        input  start_ready, busy, done, sum_out, cout
    );

    modport slave (
        input  start_valid, a_in, b_in, cin, abort,
        output start_ready, busy, done, sum_out, cout
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-add step (two half-adder cells, an OR and
// a carry flop) per clock, LSB first. An operation takes WIDTH RUN cycles plus
// one DONE cycle, so a new request can be accepted every WIDTH+2 cycles.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_add_if.slave bus
);
    // Counter only has to reach WIDTH-1; it is not incremented on the last step,
    // so it never wraps even when WIDTH is a power of two.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             carry_nx;
    logic [WIDTH-1:0] s_nx;
    logic             accept;

    // abort outranks a request in IDLE, so it masks the accept
    assign accept = bus.start_valid & bus.start_ready & ~bus.abort;

    // The shared 1-bit adder cell: HA1 on the operand bits, HA2 folds in the carry.
    always_comb begin
        p        = a_sr[0] ^ b_sr[0];
        g1       = a_sr[0] & b_sr[0];
        s        = p ^ carry;
        g2       = p & carry;
        carry_nx = g1 | g2;
        s_nx     = {s, s_sr[WIDTH-1:1]};
    end

    // Sequencer FSM with all handshake/result outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            a_sr            <= '0;
            b_sr            <= '0;
            s_sr            <= '0;
            carry           <= 1'b0;
            cnt             <= '0;
            bus.start_ready <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.sum_out     <= '0;
            bus.cout        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr            <= bus.a_in;
                        b_sr            <= bus.b_in;
                        s_sr            <= '0;
                        carry           <= bus.cin;
                        cnt             <= '0;
                        state           <= RUN;
                        bus.start_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // results stay at the previous operation; shift regs left stale
                        state           <= IDLE;
                        bus.start_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        a_sr  <= a_sr >> 1;
                        b_sr  <= b_sr >> 1;
                        s_sr  <= s_nx;
                        carry <= carry_nx;
                        if (cnt == LAST) begin
                            state       <= DONE;
                            bus.sum_out <= s_nx;
                            bus.cout    <= carry_nx;
                            bus.done    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // always exits after one cycle; abort here changes nothing
                    state           <= IDLE;
                    bus.start_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    bus.start_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule
